tt_um_emern_spi_host: RTL and testbench

//  SPI mode-0 master (host side) that drives the GPU command frontend: cs/mosi/sck out, miso in.

---
 rtl/tt_um_emern_spi_host.sv | 178 +++++++++++++++++
 tb/tb_tt_um_emern_spi_host.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/tt_um_emern_spi_host.sv
// SPI mode-0 host: sends len-byte transactions MSB-first under one CS assertion
// and returns every received byte, optionally gated by the GPU INT line.
module tt_um_emern_spi_host #(
  parameter int CLK_DIV  = 2,
  parameter int LEN_W    = 4,
  parameter int CS_GUARD = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             wait_int,
  output logic             busy,
  input  logic [7:0]       tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic [7:0]       rx_data,
  output logic             rx_valid,
  output logic             done,
  output logic             cs_out,
  output logic             sck_out,
  output logic             mosi_out,
  input  logic             miso_in,
  input  logic             int_in
);

  localparam int DIV_W = $clog2(CLK_DIV) + 1;
  localparam int GRD_W = $clog2(CS_GUARD) + 1;

  typedef enum logic [2:0] {
    IDLE, WAIT_INT, LOAD, GUARD_S, SHIFT, GUARD_E, FINISH
  } state_t;

  state_t           state;
  logic [LEN_W-1:0] remain;
  logic [2:0]       bit_cnt;
  logic [DIV_W-1:0] div;
  logic [GRD_W-1:0] gcnt;
  logic             int_meta;
  logic             int_sync;
  logic [6:0]       tx_sh;
  logic [7:0]       rx_sh;

  logic handshake;
  logic tick;
  logic rise;
  logic fall;

  always_comb begin
    handshake = (state == LOAD) && tx_valid && tx_ready;
    tick      = (state == SHIFT) && (div == DIV_W'(CLK_DIV - 1));
    rise      = tick && !sck_out;
    fall      = tick && sck_out;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      busy     <= 1'b0;
      tx_ready <= 1'b0;
      rx_valid <= 1'b0;
      done     <= 1'b0;
      rx_data  <= 8'h00;
      cs_out   <= 1'b1;
      sck_out  <= 1'b0;
      mosi_out <= 1'b0;
      remain   <= '0;
      bit_cnt  <= '0;
      div      <= '0;
      gcnt     <= '0;
      int_meta <= 1'b0;
      int_sync <= 1'b0;
    end else begin
      int_meta <= int_in;
      int_sync <= int_meta;
      rx_valid <= 1'b0;
      done     <= 1'b0;
      case (state)
        IDLE: begin
          if (start && (len != '0)) begin
            remain <= len;
            busy   <= 1'b1;
            if (wait_int) begin
              state <= WAIT_INT;
            end else begin
              state    <= LOAD;
              tx_ready <= 1'b1;
            end
          end
        end
        WAIT_INT: begin
          if (int_sync) begin
            state    <= LOAD;
            tx_ready <= 1'b1;
          end
        end
        LOAD: begin
          // CS still high here means this is the first byte of the transaction
          if (handshake) begin
            tx_ready <= 1'b0;
            mosi_out <= tx_data[7];
            bit_cnt  <= '0;
            div      <= '0;
            if (cs_out) begin
              cs_out <= 1'b0;
              gcnt   <= '0;
              state  <= GUARD_S;
            end else begin
              state <= SHIFT;
            end
          end
        end
        GUARD_S: begin
          if (gcnt == GRD_W'(CS_GUARD - 1)) begin
            gcnt  <= '0;
            state <= SHIFT;
          end else begin
            gcnt <= gcnt + 1'b1;
          end
        end
        SHIFT: begin
          if (tick) begin
            div     <= '0;
            sck_out <= ~sck_out;
            if (fall) begin
              if (bit_cnt == 3'd7) begin
                rx_data  <= rx_sh;
                rx_valid <= 1'b1;
                bit_cnt  <= '0;
                remain   <= remain - 1'b1;
                if (remain == LEN_W'(1)) begin
                  gcnt  <= '0;
                  state <= GUARD_E;
                end else begin
                  tx_ready <= 1'b1;
                  state    <= LOAD;
                end
              end else begin
                bit_cnt  <= bit_cnt + 1'b1;
                mosi_out <= tx_sh[6];
              end
            end
          end else begin
            div <= div + 1'b1;
          end
        end
        GUARD_E: begin
          if (gcnt == GRD_W'(CS_GUARD - 1)) begin
            gcnt   <= '0;
            cs_out <= 1'b1;
            done   <= 1'b1;
            state  <= FINISH;
          end else begin
            gcnt <= gcnt + 1'b1;
          end
        end
        FINISH: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Shift registers carry data only; their contents are don't-care outside a transfer
  always_ff @(posedge clk) begin
    if (handshake) begin
      tx_sh <= tx_data[6:0];
    end else if (fall && (bit_cnt != 3'd7)) begin
      tx_sh <= {tx_sh[5:0], 1'b0};
    end
    if (rise) begin
      rx_sh <= {rx_sh[6:0], miso_in};
    end
  end

endmodule

// File: tb/tb_tt_um_emern_spi_host.sv
// Directed bench for the SPI host: table of transactions plus hand-written
// sequences for INT gating, clock divider, mid-transfer reset and ignored starts.
`timescale 1ns/1ps
module tb_tt_um_emern_spi_host;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [3:0] len = 4'd0;
  logic       wait_int = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       int_in = 1'b0;
  logic       inv = 1'b0;
  logic       busy, tx_ready, rx_valid, done, cs_out, sck_out, mosi_out, miso;
  logic [7:0] rx_data;

  // Second and third hosts exercise other divider settings
  logic       start_c = 1'b0;
  logic [3:0] len_c = 4'd1;
  logic [7:0] tx_c = 8'hC6;
  logic       tv_c = 1'b1;
  logic       busy1, rdy1, rxv1, done1, cs1, sck1, mosi1;
  logic       busy4, rdy4, rxv4, done4, cs4, sck4, mosi4;
  logic [7:0] rxd1, rxd4;

  always #5 clk = ~clk;
  assign miso = mosi_out ^ inv;

  tt_um_emern_spi_host #(.CLK_DIV(2), .LEN_W(4), .CS_GUARD(2)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len), .wait_int(wait_int),
    .busy(busy), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .done(done), .cs_out(cs_out),
    .sck_out(sck_out), .mosi_out(mosi_out), .miso_in(miso), .int_in(int_in)
  );

  tt_um_emern_spi_host #(.CLK_DIV(1), .LEN_W(4), .CS_GUARD(2)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start_c), .len(len_c), .wait_int(1'b0),
    .busy(busy1), .tx_data(tx_c), .tx_valid(tv_c), .tx_ready(rdy1),
    .rx_data(rxd1), .rx_valid(rxv1), .done(done1), .cs_out(cs1),
    .sck_out(sck1), .mosi_out(mosi1), .miso_in(mosi1), .int_in(int_in)
  );

  tt_um_emern_spi_host #(.CLK_DIV(4), .LEN_W(4), .CS_GUARD(2)) u4 (
    .clk(clk), .rst_n(rst_n), .start(start_c), .len(len_c), .wait_int(1'b0),
    .busy(busy4), .tx_data(tx_c), .tx_valid(tv_c), .tx_ready(rdy4),
    .rx_data(rxd4), .rx_valid(rxv4), .done(done4), .cs_out(cs4),
    .sck_out(sck4), .mosi_out(mosi4), .miso_in(mosi4), .int_in(int_in)
  );

  int n_vec = 0;
  int n_fail = 0;

  // Bus monitors, sampled on the falling clock edge
  int         rises = 0, done_cnt = 0, viol = 0;
  logic       psck = 1'b0;
  logic [7:0] rx_q [$];
  logic       mosi_q [$];
  int         cslow1 = 0, rise1 = 0, per1 = 0, since1 = 0, dn1 = 0;
  int         cslow4 = 0, rise4 = 0, per4 = 0, since4 = 0, dn4 = 0;
  logic       psck1 = 1'b0, psck4 = 1'b0;

  always @(negedge clk) begin
    if (sck_out && !psck) begin
      rises <= rises + 1;
      mosi_q.push_back(mosi_out);
    end
    if (sck_out && cs_out) viol <= viol + 1;
    if (rx_valid) rx_q.push_back(rx_data);
    if (done) done_cnt <= done_cnt + 1;
    psck <= sck_out;
  end

  always @(negedge clk) begin
    if (!cs1) cslow1 <= cslow1 + 1;
    if (done1) dn1 <= dn1 + 1;
    if (sck1 && !psck1) begin
      rise1 <= rise1 + 1; per1 <= since1; since1 <= 1;
    end else since1 <= since1 + 1;
    psck1 <= sck1;
    if (!cs4) cslow4 <= cslow4 + 1;
    if (done4) dn4 <= dn4 + 1;
    if (sck4 && !psck4) begin
      rise4 <= rise4 + 1; per4 <= since4; since4 <= 1;
    end else since4 <= since4 + 1;
    psck4 <= sck4;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    int         len;
    logic [7:0] tx [3];
    logic [7:0] rx [3];
    logic       inv;
    int         stall;
  } vec_t;

  vec_t vecs [5];

  task automatic set_vec(input int i, input int l, input logic [7:0] t0, t1, t2,
                         input logic [7:0] e0, e1, e2, input logic iv, input int st);
    vecs[i].len = l;
    vecs[i].tx[0] = t0; vecs[i].tx[1] = t1; vecs[i].tx[2] = t2;
    vecs[i].rx[0] = e0; vecs[i].rx[1] = e1; vecs[i].rx[2] = e2;
    vecs[i].inv = iv;
    vecs[i].stall = st;
  endtask

  task automatic wait_done();
    int k = 0;
    while (!done && k < 3000) begin @(negedge clk); k++; end
    check("done_seen", done, 1);
    @(negedge clk);
  endtask

  task automatic run_vec(input vec_t v);
    int r0, q0, m0, d0, k, st_bad;
    logic [7:0] mb, rb;
    r0 = rises; q0 = rx_q.size(); m0 = mosi_q.size(); d0 = done_cnt;
    inv = v.inv; wait_int = 1'b0;
    @(negedge clk); start = 1'b1; len = 4'(v.len);
    @(negedge clk); start = 1'b0;
    for (int i = 0; i < v.len; i++) begin
      tx_data = v.tx[i];
      if (i == 1 && v.stall > 0) begin
        tx_valid = 1'b0; k = 0;
        while (!tx_ready && k < 2000) begin @(negedge clk); k++; end
        st_bad = 0;
        repeat (v.stall) begin
          @(negedge clk);
          if (sck_out || cs_out || !tx_ready) st_bad++;
        end
        check("stall_idle", st_bad, 0);
      end
      tx_valid = 1'b1; k = 0;
      while (!tx_ready && k < 2000) begin @(negedge clk); k++; end
      check("tx_ready_seen", tx_ready, 1);
      @(negedge clk); tx_valid = 1'b0;
    end
    wait_done();
    check("busy_after_done", busy, 0);
    check("done_count", done_cnt - d0, 1);
    check("sck_rises", rises - r0, 8 * v.len);
    check("rx_count", rx_q.size() - q0, v.len);
    for (int i = 0; i < v.len; i++) begin
      rb = (q0 + i < rx_q.size()) ? rx_q[q0 + i] : 8'hxx;
      check($sformatf("rx_byte%0d", i), rb, v.rx[i]);
      mb = 8'h00;
      for (int j = 0; j < 8; j++)
        mb = {mb[6:0], (m0 + 8*i + j < mosi_q.size()) ? mosi_q[m0 + 8*i + j] : 1'bx};
      check($sformatf("mosi_byte%0d", i), mb, v.tx[i]);
    end
    check("rx_data_last", rx_data, v.rx[v.len-1]);
  endtask

  initial begin
    int k, bad, r0, q0, d0;
    set_vec(0, 1, 8'hA5, 8'h00, 8'h00, 8'hA5, 8'h00, 8'h00, 1'b0, 0);
    set_vec(1, 3, 8'h01, 8'h80, 8'hFF, 8'h01, 8'h80, 8'hFF, 1'b0, 20);
    set_vec(2, 2, 8'h3C, 8'hC3, 8'h00, 8'hC3, 8'h3C, 8'h00, 1'b1, 0);
    set_vec(3, 3, 8'h00, 8'h7E, 8'h81, 8'hFF, 8'h81, 8'h7E, 1'b1, 0);
    set_vec(4, 1, 8'h5A, 8'h00, 8'h00, 8'h5A, 8'h00, 8'h00, 1'b0, 0);

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_cs", cs_out, 1);
    check("rst_sck", sck_out, 0);
    check("rst_mosi", mosi_out, 0);
    check("rst_busy", busy, 0);
    check("rst_tx_ready", tx_ready, 0);
    check("rst_rx_valid", rx_valid, 0);
    check("rst_done", done, 0);
    check("rst_rx_data", rx_data, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Divider settings 1 and 4: CS low for 2 + 16*CLK_DIV + 2 cycles
    start_c = 1'b1; @(negedge clk); start_c = 1'b0;
    repeat (120) @(negedge clk);
    check("div1_cs_low", cslow1, 20);
    check("div4_cs_low", cslow4, 68);
    check("div1_rises", rise1, 8);
    check("div4_rises", rise4, 8);
    check("div1_period", per1, 2);
    check("div4_period", per4, 8);
    check("div1_rx", rxd1, 8'hC6);
    check("div4_rx", rxd4, 8'hC6);
    check("div1_done", dn1, 1);
    check("div4_done", dn4, 1);
    tv_c = 1'b0;

    // Table of transactions
    for (int i = 0; i < 5; i++) run_vec(vecs[i]);

    // INT gating: CS held high until the synchronised INT lets the first byte load
    inv = 1'b0; tx_data = 8'h96; tx_valid = 1'b1; int_in = 1'b0;
    q0 = rx_q.size();
    @(negedge clk); start = 1'b1; len = 4'd1; wait_int = 1'b1;
    @(negedge clk); start = 1'b0; wait_int = 1'b0;
    bad = 0;
    repeat (100) begin @(negedge clk); if (!cs_out || !busy || sck_out) bad++; end
    check("int_hold_cs", bad, 0);
    int_in = 1'b1; k = 0;
    do begin @(negedge clk); k++; end while (cs_out && k < 20);
    check("int_to_cs_cycles", k, 4);
    tx_valid = 1'b0;
    wait_done();
    check("int_rx_count", rx_q.size() - q0, 1);
    check("int_rx", rx_data, 8'h96);

    // Reset during bit 4 of byte 2
    tx_data = 8'h55; tx_valid = 1'b1;
    r0 = rises; q0 = rx_q.size(); d0 = done_cnt;
    @(negedge clk); start = 1'b1; len = 4'd3;
    @(negedge clk); start = 1'b0;
    k = 0;
    while (rises - r0 < 12 && k < 2000) begin @(negedge clk); k++; end
    check("reached_bit4", rises - r0, 12);
    #2 rst_n = 1'b0;
    #1;
    check("abort_cs", cs_out, 1);
    check("abort_sck", sck_out, 0);
    check("abort_busy", busy, 0);
    tx_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("abort_no_done", done_cnt - d0, 0);
    check("abort_rx_count", rx_q.size() - q0, 1);
    run_vec(vecs[0]);

    // Start while busy is ignored
    r0 = rises; d0 = done_cnt; inv = 1'b0;
    @(negedge clk); start = 1'b1; len = 4'd1;
    @(negedge clk); start = 1'b0;
    @(negedge clk); start = 1'b1; len = 4'd2;
    @(negedge clk); start = 1'b0;
    repeat (4) @(negedge clk);
    check("busy_stall_busy", busy, 1);
    check("busy_stall_cs", cs_out, 1);
    check("busy_stall_ready", tx_ready, 1);
    tx_data = 8'h3C; tx_valid = 1'b1;
    @(negedge clk); tx_valid = 1'b0;
    wait_done();
    check("busy_start_rises", rises - r0, 8);
    check("busy_start_done", done_cnt - d0, 1);
    check("busy_start_rx", rx_data, 8'h3C);

    // Start with len=0 is ignored
    r0 = rises;
    @(negedge clk); start = 1'b1; len = 4'd0;
    @(negedge clk); start = 1'b0;
    bad = 0;
    repeat (10) begin @(negedge clk); if (busy || !cs_out || sck_out || tx_ready) bad++; end
    check("len0_ignored", bad, 0);
    check("len0_rises", rises - r0, 0);

    check("sck_with_cs_high", viol, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1);
  end

endmodule
